stream_golden_checker: RTL and testbench
========================================

Name: stream_golden_checker

Overview:
- Synthesizable, parametrised checker that compares a DUT output stream element-by-element against a golden vector held in an external synchronous ROM.
- Generalises the weighting-matrix golden test: adds parametrised width, length and absolute-difference tolerance, a stop-on-error/count-all mode, a ready/valid handshake, and error diagnostics.
- Sits between a compute block's output stream and the simulation or FPGA self-test result logic.

Parameters:
- WIDTH, 32: bits per element; elements are signed two's-complement.
- LENGTH, 64: expected element count; must be >= 1.
- TOLERANCE, 0: maximum allowed |dut - golden|; 0 means exact match.
- STOP_ON_ERROR, 1: 1 = finish on the first element mismatch; 0 = check all elements and count mismatches.
- ADDR_W, $clog2(LENGTH) (minimum 1): golden ROM address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a check run; honoured only in IDLE or DONE.
- dut_valid  in  1  DUT element valid.
- dut_data  in  WIDTH  DUT element.
- dut_last  in  1  marks the DUT's final element.
- dut_ready  out  1  checker accepts an element.
- gold_addr  out  ADDR_W  golden ROM read address.
- gold_data  in  WIDTH  ROM data; valid one cycle after gold_addr is presented.
- busy  out  1  high in PREFETCH and COMPARE.
- result  out  3  bit0 = pass, bit1 = element mismatch, bit2 = length mismatch; all zero while not finished.
- err_count  out  ADDR_W+1  number of mismatching elements.
- first_err_idx  out  ADDR_W  index of the first mismatching element.

Behaviour:
- Reset: state = IDLE; dut_ready, busy, result, err_count, first_err_idx and gold_addr all 0. A reset mid-run aborts immediately with the same values.
- States: IDLE -> PREFETCH -> COMPARE -> DONE. From DONE, start -> PREFETCH; from IDLE, start -> PREFETCH.
- PREFETCH (1 cycle): gold_addr = 0, idx = 0, counters cleared, result = 0; -> COMPARE.
- COMPARE: dut_ready = 1. A handshake is the cycle where dut_valid && dut_ready.
  - On a handshake, gold_addr advances combinationally to idx+1 and idx increments, giving full throughput of one element per cycle.
  - Without a handshake, gold_addr holds idx.
- Compare arithmetic: diff = sign-extend both operands to WIDTH+1 bits, subtract, take the absolute value in WIDTH+1 bits. The element mismatches if diff > TOLERANCE. This handles the most-negative operand without overflow.
- Mismatch handling: err_count increments and saturates at its all-ones value. first_err_idx captures idx on the first mismatch only.
- Length rules, evaluated on each handshake:
  - dut_last && idx < LENGTH-1: short stream -> result[2] set, -> DONE.
  - idx == LENGTH-1 && !dut_last: long stream -> result[2] set, -> DONE.
  - idx == LENGTH-1 && dut_last: normal end -> DONE.
- Element errors: if STOP_ON_ERROR = 1, the first mismatch sets result[1] -> DONE. A length error on the same handshake also sets result[2]; both bits may be high together.
- End of run with STOP_ON_ERROR = 0: result[1] = (err_count != 0).
- Pass: result[0] = 1 only if result[2:1] == 0 at DONE.
- Timing: result becomes visible the cycle after the deciding handshake.
- DONE: dut_ready = 0; result, err_count and first_err_idx hold until start or rst.
- start while in PREFETCH or COMPARE is ignored.
- LENGTH = 1: the first handshake is both a valid end and the last-element check.

Optional Feature:
- Macro GOLDEN_CHECKER_TIMEOUT_EN.
  - Defined: adds parameter TIMEOUT_CYCLES (default 1024) and a cycle counter that clears on every handshake and on PREFETCH. If it reaches TIMEOUT_CYCLES in COMPARE, result[2] is set and the state -> DONE (a stalled DUT is treated as a short stream).
  - Undefined: no counter is built, and COMPARE waits indefinitely for the DUT.

Test Plan:
- Exact match: WIDTH=32, LENGTH=16, TOLERANCE=0, DUT streams golden[0..15] with last on element 15 and valid held high -> result=3'b001, err_count=0, 16 handshakes in 16 consecutive cycles.
- Tolerance edges, TOLERANCE=2:
  - Golden 100, DUT 102 -> match.
  - Golden 100, DUT 97 -> mismatch.
  - Golden 0x80000000 vs DUT 0x7FFFFFFF -> mismatch, no overflow.
- Stop vs count, with mismatches at indices 3 and 9:
  - STOP_ON_ERROR=1 -> result=3'b010, first_err_idx=3, DONE one cycle after the index-3 handshake.
  - STOP_ON_ERROR=0 -> result=3'b010, err_count=2, first_err_idx=3.
- Length errors:
  - last on element 10 of 16 -> result=3'b100.
  - No last on element 15 -> result=3'b100.
  - Mismatch and early last on the same element with STOP_ON_ERROR=1 -> result=3'b110.
- Backpressure and reset:
  - Random dut_valid gaps -> gold_addr holds during gaps, result=3'b001.
  - rst asserted at element 7 -> all outputs 0 next cycle; a fresh start then passes.
- Timeout (macro defined, TIMEOUT_CYCLES=8): DUT stops after 5 elements -> result=3'b100 exactly 8 cycles after the last handshake.

Source files
------------

// File: rtl/stream_golden_checker.sv
// Streams DUT elements against a golden ROM with tolerance, length and handshake checks.
// Optional stall timeout is built when GOLDEN_CHECKER_TIMEOUT_EN is defined.
module stream_golden_checker #(
    parameter int WIDTH         = 32,
    parameter int LENGTH        = 64,
    parameter int TOLERANCE     = 0,
    parameter int STOP_ON_ERROR = 1,
    parameter int ADDR_W        = (LENGTH > 1) ? $clog2(LENGTH) : 1
`ifdef GOLDEN_CHECKER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dut_valid,
    input  logic [WIDTH-1:0]  dut_data,
    input  logic              dut_last,
    output logic              dut_ready,
    output logic [ADDR_W-1:0] gold_addr,
    input  logic [WIDTH-1:0]  gold_data,
    output logic              busy,
    output logic [2:0]        result,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        COMPARE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LENGTH - 1);
    localparam logic [WIDTH:0]    TOL_EXT  = (WIDTH + 1)'(TOLERANCE);

    state_t            state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W-1:0] first_err_reg;
    logic [ADDR_W:0]   err_count_reg;
    logic [ADDR_W:0]   err_count_next;
    logic [2:0]        result_reg;

    logic              handshake;
    logic [WIDTH:0]    dut_ext;
    logic [WIDTH:0]    gold_ext;
    logic [WIDTH:0]    diff;
    logic [WIDTH:0]    abs_diff;
    logic              mismatch;
    logic              is_last_idx;
    logic              len_err;
    logic              elem_err;
    logic              finish;
    logic              timeout_hit;

    // One extra bit keeps the difference of two extreme operands representable.
    always_comb begin
        dut_ext  = {dut_data[WIDTH-1], dut_data};
        gold_ext = {gold_data[WIDTH-1], gold_data};
        diff     = dut_ext - gold_ext;
        abs_diff = diff[WIDTH] ? (~diff + 1'b1) : diff;
        mismatch = abs_diff > TOL_EXT;
    end

    always_comb begin
        handshake      = dut_valid && (state_reg == COMPARE);
        is_last_idx    = (idx_reg == LAST_IDX);
        len_err        = (dut_last && !is_last_idx) || (is_last_idx && !dut_last);
        elem_err       = mismatch || (err_count_reg != '0);
        finish         = dut_last || is_last_idx || ((STOP_ON_ERROR != 0) && mismatch);
        err_count_next = err_count_reg;
        if (mismatch && (err_count_reg != '1)) begin
            err_count_next = err_count_reg + 1'b1;
        end
    end

    // The ROM has one cycle of read latency, so the next address is issued on the handshake itself.
    always_comb begin
        case (state_reg)
            PREFETCH: gold_addr = '0;
            COMPARE:  gold_addr = handshake ? (idx_reg + 1'b1) : idx_reg;
            default:  gold_addr = idx_reg;
        endcase
    end

`ifdef GOLDEN_CHECKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] stall_reg;

    always_ff @(posedge clk) begin
        if (rst || (state_reg != COMPARE) || handshake) begin
            stall_reg <= '0;
        end else begin
            stall_reg <= stall_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == COMPARE) && !handshake && (stall_reg == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            first_err_reg <= '0;
            err_count_reg <= '0;
            result_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg     <= PREFETCH;
                        idx_reg       <= '0;
                        first_err_reg <= '0;
                        err_count_reg <= '0;
                        result_reg    <= '0;
                    end
                end
                PREFETCH: begin
                    state_reg     <= COMPARE;
                    idx_reg       <= '0;
                    first_err_reg <= '0;
                    err_count_reg <= '0;
                    result_reg    <= '0;
                end
                COMPARE: begin
                    if (handshake) begin
                        idx_reg       <= idx_reg + 1'b1;
                        err_count_reg <= err_count_next;
                        if (mismatch && (err_count_reg == '0)) begin
                            first_err_reg <= idx_reg;
                        end
                        if (finish) begin
                            state_reg  <= DONE;
                            result_reg <= {len_err, elem_err, !(len_err || elem_err)};
                        end
                    end else if (timeout_hit) begin
                        // A stalled producer is reported as a short stream.
                        state_reg  <= DONE;
                        result_reg <= {1'b1, (err_count_reg != '0), 1'b0};
                    end
                end
            endcase
        end
    end

    assign dut_ready     = (state_reg == COMPARE);
    assign busy          = (state_reg == PREFETCH) || (state_reg == COMPARE);
    assign result        = result_reg;
    assign err_count     = err_count_reg;
    assign first_err_idx = first_err_reg;

endmodule

// File: tb/tb_stream_golden_checker.sv
// Scoreboard bench: two checker instances (stop-on-error and count-all) fed from a golden ROM model.
module tb_stream_golden_checker;

    localparam int LEN = 16;
    localparam int TOL = 2;

    typedef struct packed {
        logic [2:0] res;
        logic [4:0] ec;
        logic [3:0] fe;
        int         hs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic        dut_valid [2];
    logic        dut_last [2];
    logic        dut_ready [2];
    logic        busy [2];
    logic [31:0] dut_data [2];
    logic [31:0] gold_data [2];
    logic [3:0]  gold_addr [2];
    logic [3:0]  first_err_idx [2];
    logic [4:0]  err_count [2];
    logic [2:0]  result [2];

    logic [31:0] gold_mem [2][LEN];
    logic [31:0] stim_data [LEN];
    int          stim_last;

    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];

    int         hs_cnt [2];
    int         since [2];
    logic [2:0] prev_res [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        stream_golden_checker #(
            .WIDTH(32),
            .LENGTH(LEN),
            .TOLERANCE(TOL),
            .STOP_ON_ERROR((gi == 0) ? 1 : 0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .start(start[gi]),
            .dut_valid(dut_valid[gi]),
            .dut_data(dut_data[gi]),
            .dut_last(dut_last[gi]),
            .dut_ready(dut_ready[gi]),
            .gold_addr(gold_addr[gi]),
            .gold_data(gold_data[gi]),
            .busy(busy[gi]),
            .result(result[gi]),
            .err_count(err_count[gi]),
            .first_err_idx(first_err_idx[gi])
        );
    end

    // Synchronous golden ROM, one cycle of read latency.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            gold_data[m] <= gold_mem[m][gold_addr[m]];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the stream and apply the end/length/error rules directly.
    function automatic exp_t model(input int m);
        exp_t   e;
        int     errs;
        longint g;
        longint d;
        longint ad;
        bit     mis;
        bit     lst;
        bit     lenerr;
        bit     elemerr;
        e    = '0;
        errs = 0;
        for (int k = 0; k < LEN; k++) begin
            g   = longint'($signed(gold_mem[m][k]));
            d   = longint'($signed(stim_data[k]));
            ad  = d - g;
            if (ad < 0) ad = -ad;
            mis = (ad > TOL);
            lst = (k == stim_last);
            if (mis) begin
                if (errs == 0) e.fe = 4'(k);
                errs++;
            end
            if (lst || (k == LEN - 1) || ((m == 0) && mis)) begin
                lenerr  = (lst && (k < LEN - 1)) || ((k == LEN - 1) && !lst);
                elemerr = (errs != 0);
                e.res   = {lenerr, elemerr, !(lenerr || elemerr)};
                e.ec    = 5'(errs);
                e.hs    = k + 1;
                return e;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            if (!rst) begin
                if (busy[m] && !dut_ready[m]) begin
                    hs_cnt[m] = 0;
                    since[m]  = 0;
                end
                if (dut_ready[m]) begin
                    chk("gold_addr", gold_addr[m], (hs_cnt[m] + (dut_valid[m] ? 1 : 0)) % LEN);
                end
                if ((result[m] != 3'b000) && (prev_res[m] == 3'b000)) begin
                    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_result inst %0d: got %b expected none", m, result[m]);
                    end else begin
                        e = (m == 0) ? q0.pop_front() : q1.pop_front();
                        chk("result", result[m], e.res);
                        chk("err_count", err_count[m], e.ec);
                        chk("first_err_idx", first_err_idx[m], e.fe);
                        chk("handshakes", hs_cnt[m], e.hs);
                        chk("decide_latency", since[m], 0);
                    end
                end
                if (dut_ready[m] && dut_valid[m]) begin
                    hs_cnt[m]++;
                    since[m] = 0;
                end else begin
                    since[m]++;
                end
            end
            prev_res[m] = result[m];
        end
    end

    task automatic fill(input int m);
        for (int k = 0; k < LEN; k++) begin
            gold_mem[m][k] = $urandom;
            stim_data[k]   = gold_mem[m][k];
        end
        stim_last = LEN - 1;
    endtask

    task automatic pulse_start(input int m);
        start[m] = 1'b1;
        @(posedge clk);
        #1;
        start[m] = 1'b0;
    endtask

    task automatic drive(input int m, input int n, input int gap_pct, output int stalls);
        int  w;
        bit  aborted;
        stalls  = 0;
        aborted = 1'b0;
        for (int i = 0; i < n && !aborted; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                dut_valid[m] = 1'b0;
                dut_last[m]  = 1'b0;
                @(posedge clk);
                #1;
            end
            dut_valid[m] = 1'b1;
            dut_data[m]  = stim_data[i];
            dut_last[m]  = (i == stim_last);
            w = 0;
            forever begin
                @(negedge clk);
                if (dut_ready[m]) break;
                w++;
                if (i > 0) stalls++;
                if (w > 40) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL ready_timeout inst %0d elem %0d: got ready 0 expected 1", m, i);
                    aborted = 1'b1;
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        dut_valid[m] = 1'b0;
        dut_last[m]  = 1'b0;
    endtask

    task automatic run(input int m, input string name, input int gap_pct, output int stalls);
        exp_t e;
        int   w;
        e = model(m);
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
        pulse_start(m);
        drive(m, e.hs, gap_pct, stalls);
        w = 0;
        while (result[m] == 3'b000 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (result[m] == 3'b000) begin
            tests++;
            fails++;
            $display("[TB] FAIL done_timeout %s: got result 0 expected %b", name, e.res);
        end
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] run %s inst=%0d result=%b err_count=%0d first_err_idx=%0d (model %b/%0d/%0d)",
                 name, m, result[m], err_count[m], first_err_idx[m], e.res, e.ec, e.fe);
    endtask

    initial begin
        int st;
        int r;
        int m;
        for (int i = 0; i < 2; i++) begin
            start[i]     = 1'b0;
            dut_valid[i] = 1'b0;
            dut_last[i]  = 1'b0;
            dut_data[i]  = '0;
            hs_cnt[i]    = 0;
            since[i]     = 0;
            prev_res[i]  = '0;
            for (int k = 0; k < LEN; k++) gold_mem[i][k] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", dut_ready[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_result", result[i], 0);
            chk("rst_err_count", err_count[i], 0);
            chk("rst_first_err", first_err_idx[i], 0);
            chk("rst_gold_addr", gold_addr[i], 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        fill(1);
        run(1, "exact_match", 0, st);
        chk("consecutive_stalls", st, 0);
        fill(0);
        run(0, "exact_match_stop", 0, st);

        fill(1);
        gold_mem[1][0] = 32'd100;
        stim_data[0]   = 32'd102;
        run(1, "tol_plus2", 0, st);
        fill(1);
        gold_mem[1][4] = 32'd100;
        stim_data[4]   = 32'd97;
        run(1, "tol_minus3", 0, st);
        fill(1);
        gold_mem[1][6] = 32'h8000_0000;
        stim_data[6]   = 32'h7FFF_FFFF;
        run(1, "tol_extreme", 0, st);

        for (int i = 0; i < 2; i++) begin
            fill(i);
            stim_data[3] = gold_mem[i][3] ^ 32'h0001_0000;
            stim_data[9] = gold_mem[i][9] ^ 32'h0001_0000;
            run(i, (i == 0) ? "two_err_stop" : "two_err_count", 0, st);
        end

        fill(1);
        stim_last = 10;
        run(1, "short_stream", 0, st);
        fill(0);
        stim_last = -1;
        run(0, "long_stream", 0, st);
        fill(0);
        stim_last    = 5;
        stim_data[5] = gold_mem[0][5] + 32'd50;
        run(0, "err_and_short", 0, st);

        fill(1);
        run(1, "backpressure", 40, st);

        fill(1);
        stim_data[2] = gold_mem[1][2] ^ 32'h0000_0100;
        pulse_start(1);
        drive(1, 7, 0, st);
        chk("pre_rst_err_count", err_count[1], 1);
        dut_valid[1] = 1'b1;
        dut_data[1]  = stim_data[7];
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        dut_valid[1] = 1'b0;
        @(negedge clk);
        chk("midrst_ready", dut_ready[1], 0);
        chk("midrst_busy", busy[1], 0);
        chk("midrst_result", result[1], 0);
        chk("midrst_err_count", err_count[1], 0);
        chk("midrst_first_err", first_err_idx[1], 0);
        chk("midrst_gold_addr", gold_addr[1], 0);
        @(posedge clk);
        #1;
        stim_data[2] = gold_mem[1][2];
        run(1, "after_reset", 0, st);

        for (int t = 0; t < 12; t++) begin
            m = int'($urandom_range(1));
            fill(m);
            for (int k = 0; k < LEN; k++) begin
                r = int'($urandom_range(99));
                if (r < 8)       stim_data[k] = gold_mem[m][k] + 32'($urandom_range(4)) - 32'd2;
                else if (r < 14) stim_data[k] = gold_mem[m][k] + (r[0] ? 32'd3 : -32'd3);
                else if (r < 17) stim_data[k] = $urandom;
            end
            r = int'($urandom_range(99));
            if (r < 15)      stim_last = int'($urandom_range(LEN - 2));
            else if (r < 30) stim_last = -1;
            run(m, "random", int'($urandom_range(50)), st);
        end

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
